multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the single-datapath MIPS core. It replaces per-instruction combinational decode with a registered state machine, so one ALU and one unified memory port can be time-shared across the fetch, decode, execute, memory and writeback phases. It waits on a variable-latency memory handshake and drives every datapath mux and write-enable. It also keeps a retired-instruction counter for the bench and debug.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instruction[31:26], taken from the instruction register.
- funct  in  6  instruction[5:0], taken from the instruction register.
- zero  in  1  ALU zero flag, valid in the BRANCH state.
- memReady  in  1  memory has completed the current read or write this cycle.
- memRead  out  1  memory read request; held until memReady.
- memWrite  out  1  memory write request; held until memReady.
- iorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- irWrite  out  1  load the instruction register.
- pcEn  out  1  PC write enable (already resolved for branches).
- pcSource  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 regA (jr).
- aluSrcA  out  2  ALU A input: 00 PC, 01 regA, 10 shamt.
- aluSrcB  out  2  ALU B input: 00 regB, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate << 2.
- aluOp  out  2  ALU operation: 00 Add, 01 Sub, 10 Funct (the existing AluOpType encodings).
- regDst  out  2  destination register: 00 rt, 01 rd, 10 $31.
- regWriteSrc  out  2  writeback data: 00 ALUOut, 01 MDR, 10 PC, 11 {imm,16'b0}.
- regWrite  out  1  register file write enable.
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state  out  4  current state, for debug.
- retired  out  32  count of completed instructions.

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5.
  - R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
  - LUI_WB=12, JR=13, JAL=14. State 15 is unused and returns to FETCH.
- FETCH:
  - Drives memRead=1, iorD=0, aluSrcA=00, aluSrcB=01, aluOp=Add, pcSource=00.
  - While memReady=0, stays in FETCH with irWrite=0 and pcEn=0.
  - When memReady=1, asserts irWrite=1 and pcEn=1 in that same cycle, then goes to DECODE.
- DECODE:
  - Drives aluSrcA=00, aluSrcB=11, aluOp=Add, which precomputes the branch target into ALUOut.
  - Dispatches on opcode:
    - lw/sw → MEM_ADDR.
    - R-type → R_EXEC, or JR if funct=JR.
    - beq/bne → BRANCH.
    - j → JUMP; jal → JAL.
    - addi → ADDI_EXEC; lui → LUI_WB.
    - Any other opcode → illegal=1, then FETCH; retired is not incremented.
- MEM_ADDR: aluSrcA=01, aluSrcB=10, Add. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ / MEM_WRITE:
  - Drive iorD=1 and memRead or memWrite respectively, and hold in the state until memReady=1.
  - On memReady, MEM_READ goes to MEM_WB; MEM_WRITE goes to FETCH.
- MEM_WB: regDst=00, regWriteSrc=01, regWrite=1.
- R_EXEC: aluSrcB=00, aluOp=Funct. aluSrcA=10 when funct=SLL, otherwise 01.
- R_WB: regDst=01, regWriteSrc=00, regWrite=1.
- BRANCH:
  - aluSrcA=01, aluSrcB=00, Sub, pcSource=01.
  - pcEn = (beq & zero) | (bne & ~zero).
- JUMP: pcSource=10, pcEn=1.
- JR: pcSource=11, pcEn=1.
- JAL: regDst=10, regWriteSrc=10, regWrite=1, pcSource=10, pcEn=1.
- ADDI_EXEC: aluSrcA=01, aluSrcB=10, Add.
- ADDI_WB: regDst=00, regWriteSrc=00, regWrite=1.
- LUI_WB: regDst=00, regWriteSrc=11, regWrite=1.
- Every state not listed as going elsewhere returns to FETCH.
- Any output not named for a state is 0.
- retired increments by 1 on each transition into FETCH from a completing state. It wraps from 0xFFFFFFFF to 0.

## Timing
- rst=1 at a clock edge sets state=FETCH and retired=0.
- While rst is high, all outputs are 0, including memRead.
- Reset wins over any in-flight memory wait: an outstanding request is dropped, and fetch restarts on the first cycle after rst falls.
- Outputs are Moore-decoded from the registered state. The exceptions are irWrite, pcEn and the FETCH/MEM_* advance, which are qualified combinationally by memReady and zero in the same cycle.
- Latency in cycles with zero-wait memory (memReady tied high):
  - lw 5; sw 4; R-type 4; addi 4.
  - beq/bne 3; j 3; jr 3; jal 3; lui 3.
- Each memory wait cycle adds one cycle.
- memRead/memWrite never change while waiting, and are never asserted together.

## Configuration
- MULTICYCLE_JAL_EN defined: the JAL and JR states exist and regDst=10, pcSource=11 and regWriteSrc=10 are reachable.
- MULTICYCLE_JAL_EN undefined:
  - jal and R-type funct=JR decode as illegal (illegal pulse, back to FETCH, not retired).
  - States 13 and 14 behave as unused.

## Structure
- Shared package `cpu_pkg` holds:
  - the state encodings;
  - the pcSource, aluSrcA, aluSrcB, regDst and regWriteSrc encodings;
  - the existing opcode, funct and AluOpType constants.
- One sub-module: `multicycle_next_state`, a purely combinational next-state and illegal decode from state, opcode, funct and memReady.
- Output decode and the retired counter stay in the top module.

## Test plan
- memReady=1, add: 4 cycles (states 0→1→6→7→0); regWrite=1 with regDst=01 in cycle 4; retired=1.
- lw with memReady low for 2 cycles in MEM_READ:
  - 7 cycles total.
  - memRead held high for 3 cycles at iorD=1.
  - regWriteSrc=01 in MEM_WB.
- beq with zero=1 → pcEn=1, pcSource=01 in BRANCH; bne with zero=1 → pcEn=0; both return to FETCH.
- opcode 6'h3F → illegal pulses in DECODE, next state FETCH, retired unchanged.
- rst asserted mid-MEM_WRITE with memReady=0 → next cycle state=0, memWrite=0, retired=0.
- jal:
  - With MULTICYCLE_JAL_EN: 3 cycles, and in the JAL state regDst=10, regWriteSrc=10, pcEn=1.
  - Without the macro: illegal=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
// States, datapath mux selects, opcodes, funct codes and ALU op types.
package cpu_pkg;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_R_EXEC    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EXEC = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;
    localparam logic [3:0] S_LUI_WB    = 4'd12;
    localparam logic [3:0] S_JR        = 4'd13;
    localparam logic [3:0] S_JAL       = 4'd14;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REGA   = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REGA  = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;
    localparam logic [1:0] WB_LUI    = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_JR  = 6'h08;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } AluOpType;

endpackage

// File: rtl/multicycle_next_state.sv
// Combinational next-state and illegal-opcode decode for multicycle_control.
// MULTICYCLE_JAL_EN enables the jal and jr dispatch targets.
module multicycle_next_state
    import cpu_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       memReady,
    output logic [3:0] nextState,
    output logic       illegal
);

    always_comb begin
        nextState = S_FETCH;
        illegal   = 1'b0;
        case (state)
            S_FETCH:     nextState = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   nextState = S_MEM_ADDR;
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
`ifdef MULTICYCLE_JAL_EN
                            nextState = S_JR;
`else
                            illegal = 1'b1;
`endif
                        end else begin
                            nextState = S_R_EXEC;
                        end
                    end
                    OP_BEQ, OP_BNE: nextState = S_BRANCH;
                    OP_J:           nextState = S_JUMP;
`ifdef MULTICYCLE_JAL_EN
                    OP_JAL:         nextState = S_JAL;
`endif
                    OP_ADDI:        nextState = S_ADDI_EXEC;
                    OP_LUI:         nextState = S_LUI_WB;
                    default:        illegal = 1'b1;
                endcase
            end
            S_MEM_ADDR:  nextState = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  nextState = memReady ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: nextState = memReady ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    nextState = S_R_WB;
            S_ADDI_EXEC: nextState = S_ADDI_WB;
            default:     nextState = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: state register, Moore output decode, retire counter.
// MULTICYCLE_JAL_EN enables the JAL and JR states.
module multicycle_control
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        memReady,
    output logic        memRead,
    output logic        memWrite,
    output logic        iorD,
    output logic        irWrite,
    output logic        pcEn,
    output logic [1:0]  pcSource,
    output logic [1:0]  aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  aluOp,
    output logic [1:0]  regDst,
    output logic [1:0]  regWriteSrc,
    output logic        regWrite,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    logic [3:0]  stateQ;
    logic [3:0]  nextState;
    logic        illegalNs;
    logic [31:0] retiredQ;
    logic        lastState;

    multicycle_next_state uNext (
        .state     (stateQ),
        .opcode    (opcode),
        .funct     (funct),
        .memReady  (memReady),
        .nextState (nextState),
        .illegal   (illegalNs)
    );

    // States whose exit into FETCH completes an instruction
    always_comb begin
        lastState = 1'b0;
        case (stateQ)
            S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH,
            S_JUMP, S_ADDI_WB, S_LUI_WB: lastState = 1'b1;
`ifdef MULTICYCLE_JAL_EN
            S_JR, S_JAL:                 lastState = 1'b1;
`endif
            default:                     lastState = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= S_FETCH;
            retiredQ <= 32'd0;
        end else begin
            stateQ <= nextState;
            if (lastState && nextState == S_FETCH)
                retiredQ <= retiredQ + 32'd1;
        end
    end

    assign state   = rst ? 4'd0 : stateQ;
    assign retired = rst ? 32'd0 : retiredQ;
    assign illegal = ~rst & illegalNs;

    always_comb begin
        memRead     = 1'b0;
        memWrite    = 1'b0;
        iorD        = 1'b0;
        irWrite     = 1'b0;
        pcEn        = 1'b0;
        pcSource    = PC_ALU;
        aluSrcA     = SRCA_PC;
        aluSrcB     = SRCB_REGB;
        aluOp       = ALU_ADD;
        regDst      = DST_RT;
        regWriteSrc = WB_ALUOUT;
        regWrite    = 1'b0;
        if (!rst) begin
            case (stateQ)
                S_FETCH: begin
                    memRead = 1'b1;
                    aluSrcB = SRCB_FOUR;
                    irWrite = memReady;
                    pcEn    = memReady;
                end
                S_DECODE:    aluSrcB = SRCB_IMMSH;
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    aluSrcA = SRCA_REGA;
                    aluSrcB = SRCB_IMM;
                end
                S_MEM_READ: begin
                    iorD    = 1'b1;
                    memRead = 1'b1;
                end
                S_MEM_WRITE: begin
                    iorD     = 1'b1;
                    memWrite = 1'b1;
                end
                S_MEM_WB: begin
                    regWriteSrc = WB_MDR;
                    regWrite    = 1'b1;
                end
                S_R_EXEC: begin
                    aluOp   = ALU_FUNCT;
                    aluSrcA = (funct == FN_SLL) ? SRCA_SHAMT : SRCA_REGA;
                end
                S_R_WB: begin
                    regDst   = DST_RD;
                    regWrite = 1'b1;
                end
                S_BRANCH: begin
                    aluSrcA  = SRCA_REGA;
                    aluOp    = ALU_SUB;
                    pcSource = PC_ALUOUT;
                    pcEn     = ((opcode == OP_BEQ) & zero)
                             | ((opcode == OP_BNE) & ~zero);
                end
                S_JUMP: begin
                    pcSource = PC_JUMP;
                    pcEn     = 1'b1;
                end
                S_ADDI_WB:   regWrite = 1'b1;
                S_LUI_WB: begin
                    regWriteSrc = WB_LUI;
                    regWrite    = 1'b1;
                end
`ifdef MULTICYCLE_JAL_EN
                S_JR: begin
                    pcSource = PC_REGA;
                    pcEn     = 1'b1;
                end
                S_JAL: begin
                    regDst      = DST_RA;
                    regWriteSrc = WB_PC;
                    regWrite    = 1'b1;
                    pcSource    = PC_JUMP;
                    pcEn        = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expectations queued by
// the stimulus, popped and compared by a negedge monitor.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic        zero = 1'b0;
    logic        memReady = 1'b0;
    logic        memRead, memWrite, iorD, irWrite, pcEn;
    logic [1:0]  pcSource, aluSrcA, aluSrcB, aluOp, regDst, regWriteSrc;
    logic        regWrite, illegal;
    logic [3:0]  state;
    logic [31:0] retired;

    int nAssert = 0;
    int nFail = 0;

    typedef struct {
        string name;
        int st, ret, mRd, mWr, iorD, irW, pcEn, pcSrc;
        int srcA, srcB, aluOp, rDst, wbSrc, rW, ill;
    } Exp;

    Exp q[$];

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .zero(zero), .memReady(memReady),
        .memRead(memRead), .memWrite(memWrite), .iorD(iorD),
        .irWrite(irWrite), .pcEn(pcEn), .pcSource(pcSource),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .regDst(regDst), .regWriteSrc(regWriteSrc), .regWrite(regWrite),
        .illegal(illegal), .state(state), .retired(retired)
    );

    function automatic Exp e(string n, int st, int ret);
        Exp x;
        x.name = n; x.st = st; x.ret = ret;
        x.mRd = 0; x.mWr = 0; x.iorD = 0; x.irW = 0; x.pcEn = 0;
        x.pcSrc = 0; x.srcA = 0; x.srcB = 0; x.aluOp = 0;
        x.rDst = 0; x.wbSrc = 0; x.rW = 0; x.ill = 0;
        return x;
    endfunction

    function automatic Exp eFetch(string n, int ready, int ret);
        Exp x = e(n, 0, ret);
        x.mRd = 1; x.srcB = 1; x.irW = ready; x.pcEn = ready;
        return x;
    endfunction

    function automatic Exp eDecode(string n, int ret);
        Exp x = e(n, 1, ret);
        x.srcB = 3;
        return x;
    endfunction

    task automatic chk(string n, string f, int act, int exp);
        nAssert++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s.%s: got %0d expected %0d", n, f, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            Exp x;
            x = q.pop_front();
            chk(x.name, "state", int'(state), x.st);
            chk(x.name, "retired", int'(retired), x.ret);
            chk(x.name, "memRead", int'(memRead), x.mRd);
            chk(x.name, "memWrite", int'(memWrite), x.mWr);
            chk(x.name, "iorD", int'(iorD), x.iorD);
            chk(x.name, "irWrite", int'(irWrite), x.irW);
            chk(x.name, "pcEn", int'(pcEn), x.pcEn);
            chk(x.name, "pcSource", int'(pcSource), x.pcSrc);
            chk(x.name, "aluSrcA", int'(aluSrcA), x.srcA);
            chk(x.name, "aluSrcB", int'(aluSrcB), x.srcB);
            chk(x.name, "aluOp", int'(aluOp), x.aluOp);
            chk(x.name, "regDst", int'(regDst), x.rDst);
            chk(x.name, "regWriteSrc", int'(regWriteSrc), x.wbSrc);
            chk(x.name, "regWrite", int'(regWrite), x.rW);
            chk(x.name, "illegal", int'(illegal), x.ill);
        end
    end

    task automatic cyc(input logic r, input logic mr, input logic z,
                       input logic [5:0] op, input logic [5:0] fn,
                       input Exp x);
        @(posedge clk);
        #1;
        rst = r; memReady = mr; zero = z; opcode = op; funct = fn;
        q.push_back(x);
    endtask

    initial begin
        Exp x;
        int ret;
        ret = 0;

        cyc(1, 0, 0, 6'h00, 6'h00, e("reset0", 0, 0));
        cyc(1, 1, 0, 6'h00, 6'h20, e("reset1", 0, 0));

        // add, zero-wait memory
        cyc(0, 1, 0, 6'h00, 6'h20, eFetch("addF", 1, ret));
        cyc(0, 1, 0, 6'h00, 6'h20, eDecode("addD", ret));
        x = e("addX", 6, ret); x.srcA = 1; x.aluOp = 2;
        cyc(0, 1, 0, 6'h00, 6'h20, x);
        x = e("addW", 7, ret); x.rDst = 1; x.rW = 1;
        cyc(0, 1, 0, 6'h00, 6'h20, x);
        ret++;

        // fetch wait, then lw with 2 wait cycles in MEM_READ
        cyc(0, 0, 0, 6'h23, 6'h00, eFetch("lwFwait", 0, ret));
        cyc(0, 1, 0, 6'h23, 6'h00, eFetch("lwF", 1, ret));
        cyc(0, 1, 0, 6'h23, 6'h00, eDecode("lwD", ret));
        x = e("lwA", 2, ret); x.srcA = 1; x.srcB = 2;
        cyc(0, 1, 0, 6'h23, 6'h00, x);
        x = e("lwR0", 3, ret); x.iorD = 1; x.mRd = 1;
        cyc(0, 0, 0, 6'h23, 6'h00, x);
        x.name = "lwR1";
        cyc(0, 0, 0, 6'h23, 6'h00, x);
        x.name = "lwR2";
        cyc(0, 1, 0, 6'h23, 6'h00, x);
        x = e("lwW", 4, ret); x.wbSrc = 1; x.rW = 1;
        cyc(0, 1, 0, 6'h23, 6'h00, x);
        ret++;

        // beq taken
        cyc(0, 1, 1, 6'h04, 6'h00, eFetch("beqF", 1, ret));
        cyc(0, 1, 1, 6'h04, 6'h00, eDecode("beqD", ret));
        x = e("beqB", 8, ret); x.srcA = 1; x.aluOp = 1;
        x.pcSrc = 1; x.pcEn = 1;
        cyc(0, 1, 1, 6'h04, 6'h00, x);
        ret++;

        // bne not taken
        cyc(0, 1, 1, 6'h05, 6'h00, eFetch("bneF", 1, ret));
        cyc(0, 1, 1, 6'h05, 6'h00, eDecode("bneD", ret));
        x = e("bneB", 8, ret); x.srcA = 1; x.aluOp = 1; x.pcSrc = 1;
        cyc(0, 1, 1, 6'h05, 6'h00, x);
        ret++;

        // illegal opcode
        cyc(0, 1, 0, 6'h3F, 6'h00, eFetch("illF", 1, ret));
        x = eDecode("illD", ret); x.ill = 1;
        cyc(0, 1, 0, 6'h3F, 6'h00, x);

        // jal
        cyc(0, 1, 0, 6'h03, 6'h00, eFetch("jalF", 1, ret));
`ifdef MULTICYCLE_JAL_EN
        cyc(0, 1, 0, 6'h03, 6'h00, eDecode("jalD", ret));
        x = e("jalJ", 14, ret); x.rDst = 2; x.wbSrc = 2; x.rW = 1;
        x.pcSrc = 2; x.pcEn = 1;
        cyc(0, 1, 0, 6'h03, 6'h00, x);
        ret++;
`else
        x = eDecode("jalD", ret); x.ill = 1;
        cyc(0, 1, 0, 6'h03, 6'h00, x);
`endif

        // sw, reset while waiting in MEM_WRITE
        cyc(0, 1, 0, 6'h2B, 6'h00, eFetch("swF", 1, ret));
        cyc(0, 1, 0, 6'h2B, 6'h00, eDecode("swD", ret));
        x = e("swA", 2, ret); x.srcA = 1; x.srcB = 2;
        cyc(0, 1, 0, 6'h2B, 6'h00, x);
        x = e("swM", 5, ret); x.iorD = 1; x.mWr = 1;
        cyc(0, 0, 0, 6'h2B, 6'h00, x);
        cyc(1, 0, 0, 6'h2B, 6'h00, e("swRst", 0, 0));
        ret = 0;
        cyc(0, 0, 0, 6'h2B, 6'h00, eFetch("swAfter", 0, ret));

        // addi
        cyc(0, 1, 0, 6'h08, 6'h00, eFetch("addiF", 1, ret));
        cyc(0, 1, 0, 6'h08, 6'h00, eDecode("addiD", ret));
        x = e("addiX", 10, ret); x.srcA = 1; x.srcB = 2;
        cyc(0, 1, 0, 6'h08, 6'h00, x);
        x = e("addiW", 11, ret); x.rW = 1;
        cyc(0, 1, 0, 6'h08, 6'h00, x);
        ret++;

        // lui
        cyc(0, 1, 0, 6'h0F, 6'h00, eFetch("luiF", 1, ret));
        cyc(0, 1, 0, 6'h0F, 6'h00, eDecode("luiD", ret));
        x = e("luiW", 12, ret); x.wbSrc = 3; x.rW = 1;
        cyc(0, 1, 0, 6'h0F, 6'h00, x);
        ret++;

        // j
        cyc(0, 1, 0, 6'h02, 6'h00, eFetch("jF", 1, ret));
        cyc(0, 1, 0, 6'h02, 6'h00, eDecode("jD", ret));
        x = e("jJ", 9, ret); x.pcSrc = 2; x.pcEn = 1;
        cyc(0, 1, 0, 6'h02, 6'h00, x);
        ret++;

        // sll selects shamt
        cyc(0, 1, 0, 6'h00, 6'h00, eFetch("sllF", 1, ret));
        cyc(0, 1, 0, 6'h00, 6'h00, eDecode("sllD", ret));
        x = e("sllX", 6, ret); x.srcA = 2; x.aluOp = 2;
        cyc(0, 1, 0, 6'h00, 6'h00, x);
        x = e("sllW", 7, ret); x.rDst = 1; x.rW = 1;
        cyc(0, 1, 0, 6'h00, 6'h00, x);
        ret++;
        cyc(0, 0, 0, 6'h00, 6'h00, eFetch("end", 0, ret));

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        nAssert++;
        if (q.size() != 0) begin
            nFail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAssert, nFail);
        $finish;
    end

endmodule
